// File: rtl/alu_exec_sequencer.sv
// Multi-cycle RV32I instruction sequencer: owns the PC, steps fetch/decode/exec/mem/wb around an external ALU.
// Latency 4 cycles (5 for LOAD/STORE) with same-cycle ack; memory waits stretch FETCH/MEM, bounded by MEM_TIMEOUT.
module alu_exec_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  input  logic [31:0] imm,
  output logic        alu_src,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [31:0] alu_result,
  input  logic        alu_branch,
  output logic [31:0] pc,
  output logic [31:0] load_data,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal,
  output logic        timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Last count value before the timeout fires; the trap is taken on the edge the count would reach MEM_TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state;
  logic [7:0] wait_cnt;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_lui, is_legal;

  assign is_r      = (instr[6:0] == OP_R);
  assign is_i      = (instr[6:0] == OP_I);
  assign is_load   = (instr[6:0] == OP_LOAD);
  assign is_store  = (instr[6:0] == OP_STORE);
  assign is_branch = (instr[6:0] == OP_BRANCH);
  assign is_jal    = (instr[6:0] == OP_JAL);
  assign is_lui    = (instr[6:0] == OP_LUI);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_lui;

  assign alu_opcode = instr[6:0];
  assign alu_funct3 = instr[14:12];
  assign alu_funct7 = instr[31:25];
  assign alu_src    = is_i | is_load | is_store;

  // Request outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    mem_req  = (state == S_FETCH) || (state == S_MEM);
    mem_we   = (state == S_MEM) && is_store;
    mem_addr = (state == S_MEM) ? alu_result : pc;
    retire   = (state == S_WB);
    reg_we   = (state == S_WB) && (is_r | is_i | is_load | is_jal | is_lui);
    wb_sel   = 2'b00;
    if (state == S_WB) begin
      if (is_load)     wb_sel = 2'b01;
      else if (is_jal) wb_sel = 2'b10;
      else if (is_lui) wb_sel = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      instr     <= 32'h0;
      load_data <= 32'h0;
      wait_cnt  <= 8'h0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (mem_ack) begin
            wait_cnt <= 8'h0;
            if (state == S_FETCH) begin
              instr <= mem_rdata;
              state <= S_DECODE;
            end else begin
              if (is_load) load_data <= mem_rdata;
              state <= S_WB;
            end
          end else if (wait_cnt == TO_LAST) begin
            wait_cnt <= 8'h0;
            timeout  <= 1'b1;
            state    <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 8'h1;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            state   <= S_TRAP;
          end
        end
        S_EXEC: state <= (is_load || is_store) ? S_MEM : S_WB;
        S_WB: begin
          if ((is_branch && alu_branch) || is_jal) pc <= pc + imm;
          else                                      pc <= pc + 32'd4;
          state <= run ? S_FETCH : S_IDLE;
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle instruction controller for the RV32I core. It owns the PC and sequences each instruction through fetch, decode, execute, memory and writeback around the shared combinational ALU.
- Drives ALU_source/opcode/funct3/funct7 from the latched instruction, samples ALU result and branch, and runs a single-port memory req/ack handshake.
- Raises register-file write strobes and traps on illegal opcodes or a memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 255, max cycles req may stay high without ack before trapping (8-bit counter).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  allow fetching new instructions
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1=store, 0=read
- mem_addr  out  32  pc in fetch, alu_result in MEM
- mem_ack  in  1  request accepted/completed this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- instr  out  32  latched instruction, feeds decoder/regfile/immediate gen
- imm  in  32  sign-extended immediate from immediate gen
- alu_src  out  1  ALU_source: 1=immediate, 0=reg2
- alu_opcode  out  7  instr[6:0]
- alu_funct3  out  3  instr[14:12]
- alu_funct7  out  7  instr[31:25]
- alu_result  in  32  ALU result
- alu_branch  in  1  ALU branch-taken flag
- pc  out  32  current PC
- load_data  out  32  latched mem_rdata for loads
- reg_we  out  1  regfile write strobe, 1-cycle pulse
- wb_sel  out  2  00 alu_result, 01 load_data, 10 pc+4, 11 imm
- retire  out  1  1-cycle pulse per completed instruction
- illegal  out  1  sticky illegal-opcode trap flag
- timeout  out  1  sticky memory-timeout trap flag

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, instr=0, load_data=0, all strobes/flags=0, wb_sel=00, timeout counter=0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: outputs quiet. run=1 goes to FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack, instr<=mem_rdata and go to DECODE.
- DECODE (1 cycle): classify instr[6:0]. Legal opcodes are R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111. Any other opcode sets illegal=1 and goes to TRAP; pc is unchanged.
- EXEC (1 cycle): ALU inputs are stable. LOAD and STORE go to MEM; all others go to WB.
- alu_src=1 for I, LOAD and STORE; 0 otherwise. alu_* outputs are driven from instr in every state.
- MEM: mem_req=1, mem_addr=alu_result, mem_we=1 for STORE. On mem_ack, a LOAD captures load_data<=mem_rdata. Then go to WB.
- WB (1 cycle): retire=1. reg_we=1 for R, I, LOAD, JAL and LUI; 0 for STORE and BRANCH.
- WB wb_sel: R/I=00, LOAD=01, JAL=10, LUI=11.
- WB pc update: BRANCH with alu_branch=1, or JAL, gives pc<=pc+imm. Everything else gives pc<=pc+4. Arithmetic is 32-bit modulo 2^32 (wraps).
- Leaving WB: run=1 goes to FETCH, else IDLE. Dropping run mid-instruction always completes the current instruction.
- Handshake: mem_addr and mem_we are stable while mem_req=1. mem_ack with mem_req=0 is ignored. Ack is accepted in the first cycle of req at the earliest.
- Latency with same-cycle ack: R/I/BRANCH/JAL/LUI take 4 cycles; LOAD/STORE take 5.
- Timeout: the counter increments each cycle in FETCH/MEM without ack and clears on ack or state exit. When the count reaches MEM_TIMEOUT, set timeout=1, drop mem_req and go to TRAP.
- TRAP: all strobes 0 and pc frozen. Exited only by rst.
- rst mid-transaction: mem_req drops immediately (async) and no write strobe is issued.

Test Plan:
- R add: instr 0x002081B3 acked at pc=0 -> reg_we pulses in cycle 4 with wb_sel=00, alu_src=0, alu_opcode=0110011; pc=4; retire=1.
- LOAD: instr 0x0000A183, alu_result=0x100, data ack returns 0xDEADBEEF after 3 wait cycles -> mem_addr=0x100, mem_we=0, load_data=0xDEADBEEF, wb_sel=01, reg_we=1.
- STORE at pc=0x8 -> MEM cycle with mem_we=1 and mem_addr=alu_result; reg_we stays 0; pc=0xC.
- BRANCH at pc=0x20, imm=0xFFFFFFF0: alu_branch=1 gives pc=0x10; alu_branch=0 gives pc=0x24; reg_we=0 in both cases.
- Illegal opcode 0x0000007F -> illegal=1 and state TRAP; no further mem_req until rst, after which pc=RESET_PC.
- MEM_TIMEOUT=4 with no ack in FETCH -> timeout=1 after 4 cycles and mem_req=0. Also assert rst mid-FETCH -> mem_req=0 asynchronously.
